// File: rtl/dual_port_rom_if.sv
// dual_port_rom_if: read bus for the two-port constant ROM.
// Signals: en_a/en_b read enables, add_a/add_b read addresses (master -> slave);
// d_ra/d_rb registered read data (slave -> master).
interface dual_port_rom_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  en_a;
    logic                  en_b;
    logic [ADDR_WIDTH-1:0] add_a;
    logic [ADDR_WIDTH-1:0] add_b;
    logic [DATA_WIDTH-1:0] d_ra;
    logic [DATA_WIDTH-1:0] d_rb;
    modport master (output en_a, en_b, add_a, add_b, input d_ra, d_rb);
    modport slave (input en_a, en_b, add_a, add_b, output d_ra, d_rb);
endinterface

// File: rtl/dual_port_rom.sv
// dual_port_rom: 16 x 8 constant table with two independent registered read ports.
// Ports: clk clock; rst_n async active-low reset (clears both outputs);
// bus (slave) carries en_a/en_b, add_a/add_b in and d_ra/d_rb out, one cycle latency.
module dual_port_rom #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    dual_port_rom_if.slave   bus
);
    localparam logic [7:0] ROM [16] = '{
        8'd10,  8'd20,  8'd30,  8'd40,  8'd50,  8'd60,  8'd70,  8'd80,
        8'd90,  8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150, 8'd160
    };
    // Entries beyond the 16-word table read as zero when the address bus is wider.
    function automatic logic [DATA_WIDTH-1:0] rom_lookup(input logic [ADDR_WIDTH-1:0] a);
        logic [3:0] idx;
        idx = a[3:0];
        return ((a >> 4) == '0) ? DATA_WIDTH'(ROM[idx]) : '0;
    endfunction
    logic [DATA_WIDTH-1:0] w_data_a;
    logic [DATA_WIDTH-1:0] w_data_b;
    logic [DATA_WIDTH-1:0] r_d_ra;
    logic [DATA_WIDTH-1:0] r_d_rb;
    always_comb begin
        w_data_a = rom_lookup(bus.add_a);
        w_data_b = rom_lookup(bus.add_b);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_ra <= '0;
            r_d_rb <= '0;
        end else begin
            if (bus.en_a) r_d_ra <= w_data_a;
            if (bus.en_b) r_d_rb <= w_data_b;
        end
    end
    assign bus.d_ra = r_d_ra;
    assign bus.d_rb = r_d_rb;
endmodule

// File: tb/tb_dual_port_rom.sv
// tb_dual_port_rom: directed-vector bench for dual_port_rom.
module tb_dual_port_rom;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   exp_tbl [16] = '{10, 20, 30, 40, 50, 60, 70, 80,
                           90, 100, 110, 120, 130, 140, 150, 160};

    dual_port_rom_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    dual_port_rom #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ea, input logic eb, input logic [3:0] aa, input logic [3:0] ab);
        bus.en_a  = ea;
        bus.en_b  = eb;
        bus.add_a = aa;
        bus.add_b = ab;
    endtask

    // Advance one rising edge and come back to the quiet falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        #2;
        check_val("reset_a", bus.d_ra, 8'd0);
        check_val("reset_b", bus.d_rb, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        check_val("post_reset_idle_a", bus.d_ra, 8'd0);
        check_val("post_reset_idle_b", bus.d_rb, 8'd0);

        drive(1'b1, 1'b0, 4'd0, 4'd2);
        step();
        check_val("porta_only_a", bus.d_ra, 8'd10);
        check_val("porta_only_b", bus.d_rb, 8'd0);

        drive(1'b1, 1'b1, 4'd1, 4'd3);
        #1;
        check_val("latency_pre_a", bus.d_ra, 8'd10);
        check_val("latency_pre_b", bus.d_rb, 8'd0);
        @(negedge clk);
        check_val("both_1_3_a", bus.d_ra, 8'd20);
        check_val("both_1_3_b", bus.d_rb, 8'd40);
        drive(1'b1, 1'b1, 4'd5, 4'd1);
        step();
        check_val("both_5_1_a", bus.d_ra, 8'd60);
        check_val("both_5_1_b", bus.d_rb, 8'd20);
        drive(1'b1, 1'b1, 4'd4, 4'd6);
        step();
        check_val("both_4_6_a", bus.d_ra, 8'd50);
        check_val("both_4_6_b", bus.d_rb, 8'd70);

        drive(1'b1, 1'b1, 4'd10, 4'd12);
        step();
        check_val("upper_a", bus.d_ra, 8'd110);
        check_val("upper_b", bus.d_rb, 8'd130);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'(i + 2), 4'(7 - i));
            step();
            check_val("hold_a", bus.d_ra, 8'd110);
            check_val("hold_b", bus.d_rb, 8'd130);
        end

        // Mid-cycle asynchronous reset with nonzero outputs.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_a", bus.d_ra, 8'd0);
        check_val("async_rst_b", bus.d_rb, 8'd0);
        drive(1'b1, 1'b1, 4'd5, 4'd5);
        step();
        check_val("in_rst_a", bus.d_ra, 8'd0);
        check_val("in_rst_b", bus.d_rb, 8'd0);
        drive(1'b0, 1'b0, 4'd9, 4'd9);
        rst_n = 1'b1;
        step();
        check_val("release_idle_a", bus.d_ra, 8'd0);
        check_val("release_idle_b", bus.d_rb, 8'd0);

        drive(1'b1, 1'b1, 4'd15, 4'd15);
        step();
        check_val("same_addr_a", bus.d_ra, 8'd160);
        check_val("same_addr_b", bus.d_rb, 8'd160);

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 4'(i), 4'(i));
            step();
            check_val("sweep_a", bus.d_ra, 8'(exp_tbl[i]));
            check_val("sweep_b", bus.d_rb, 8'(exp_tbl[i]));
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 4'(i), 4'(15 - i));
            step();
            check_val("cross_a", bus.d_ra, 8'(exp_tbl[i]));
            check_val("cross_b", bus.d_rb, 8'(exp_tbl[15 - i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
